// File: rtl/text_port_arbiter.sv
// Text-buffer write port arbiter: round-robin between two requesters plus an optional
// whole-buffer fill engine, compiled in when TEXT_ARB_FILL_EN is defined.
module text_port_arbiter #(
    parameter int NUM_CELLS = 1920
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqA,
    input  logic [12:0] AddrA,
    input  logic [17:0] DataA,
    output logic        AckA,
    input  logic        ReqB,
    input  logic [12:0] AddrB,
    input  logic [17:0] DataB,
    output logic        AckB,
    input  logic        FillStart,
    input  logic [17:0] FillData,
    output logic        FillBusy,
    output logic [12:0] WAddr,
    output logic [17:0] WData,
    output logic        Write
);

    localparam logic [12:0] LAST_ADDR = 13'(NUM_CELLS - 1);
    localparam logic [13:0] CELL_LIM  = 14'(NUM_CELLS);

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state_q;
    logic        write_q;
    logic [12:0] waddr_q;
    logic [17:0] wdata_q;
    logic        acka_q;
    logic        ackb_q;
    logic        last_b_q;

    logic        elig_a_d;
    logic        elig_b_d;
    logic        grant_a_d;
    logic        grant_b_d;
    logic        grant_d;
    logic [12:0] sel_addr_d;
    logic [17:0] sel_data_d;
    logic        in_range_d;
    logic        fill_go_d;

    // A requester being acked this cycle sits out, so a lone requester gets every other slot.
    always_comb begin
        elig_a_d   = ReqA && !acka_q;
        elig_b_d   = ReqB && !ackb_q;
        grant_a_d  = elig_a_d && (!elig_b_d || last_b_q);
        grant_b_d  = elig_b_d && !grant_a_d;
        grant_d    = grant_a_d || grant_b_d;
        sel_addr_d = grant_a_d ? AddrA : AddrB;
        sel_data_d = grant_a_d ? DataA : DataB;
        in_range_d = {1'b0, sel_addr_d} < CELL_LIM;
`ifdef TEXT_ARB_FILL_EN
        fill_go_d  = FillStart;
`else
        fill_go_d  = 1'b0;
`endif
    end

`ifdef TEXT_ARB_FILL_EN
    logic busy_q;
    assign FillBusy = busy_q;
`else
    logic unused_fill;
    assign unused_fill = ^{FillStart, FillData};
    assign FillBusy    = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            acka_q   <= 1'b0;
            ackb_q   <= 1'b0;
            last_b_q <= 1'b1;
`ifdef TEXT_ARB_FILL_EN
            busy_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (fill_go_d) begin
                        // Fill wins over requests; the first fill write goes out next cycle.
                        state_q <= FILL;
                        write_q <= 1'b1;
                        waddr_q <= '0;
                        wdata_q <= FillData;
                        acka_q  <= 1'b0;
                        ackb_q  <= 1'b0;
`ifdef TEXT_ARB_FILL_EN
                        busy_q  <= 1'b1;
`endif
                    end else begin
                        acka_q  <= grant_a_d;
                        ackb_q  <= grant_b_d;
                        write_q <= grant_d && in_range_d;
                        if (grant_d && in_range_d) begin
                            waddr_q <= sel_addr_d;
                            wdata_q <= sel_data_d;
                        end
                        if (grant_d) begin
                            last_b_q <= grant_b_d;
                        end
                    end
                end
`ifdef TEXT_ARB_FILL_EN
                FILL: begin
                    acka_q <= 1'b0;
                    ackb_q <= 1'b0;
                    if (waddr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        write_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        write_q <= 1'b1;
                        waddr_q <= waddr_q + 13'd1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    write_q <= 1'b0;
                    acka_q  <= 1'b0;
                    ackb_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Write = write_q;
    assign WAddr = waddr_q;
    assign WData = wdata_q;
    assign AckA  = acka_q;
    assign AckB  = ackb_q;

endmodule

// File: tb/tb_text_port_arbiter.sv
// Directed bench for text_port_arbiter; fill checks run only when TEXT_ARB_FILL_EN is defined.
module tb_text_port_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqA, ReqB, FillStart;
    logic [12:0] AddrA, AddrB;
    logic [17:0] DataA, DataB, FillData;
    logic        AckA, AckB, FillBusy, Write;
    logic [12:0] WAddr;
    logic [17:0] WData;

    int total = 0;
    int bad   = 0;

    text_port_arbiter #(.NUM_CELLS(1920)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .AckA(AckA),
        .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .AckB(AckB),
        .FillStart(FillStart), .FillData(FillData), .FillBusy(FillBusy),
        .WAddr(WAddr), .WData(WData), .Write(Write)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int busy_cnt;
        int seq_err;
        logic [12:0] exp_addr;

        Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0; FillStart = 1'b0;
        AddrA = '0; AddrB = '0; DataA = '0; DataB = '0; FillData = '0;
        step(); step();
        check("rst_write", Write, 0);
        check("rst_acka", AckA, 0);
        check("rst_ackb", AckB, 0);
        check("rst_busy", FillBusy, 0);
        check("rst_waddr", WAddr, 0);
        check("rst_wdata", WData, 0);

        // requests ignored while reset is high
        ReqA = 1'b1; AddrA = 13'd5; DataA = 18'h00F48;
        step();
        check("rst_ign_write", Write, 0);
        check("rst_ign_acka", AckA, 0);

        // single A write
        Reset = 1'b0;
        step();
        check("a1_write", Write, 1);
        check("a1_waddr", WAddr, 5);
        check("a1_wdata", WData, 18'h00F48);
        check("a1_acka", AckA, 1);
        ReqA = 1'b0;
        step();
        check("a1_drop_write", Write, 0);
        check("a1_drop_acka", AckA, 0);
        step();
        check("a1_idle_write", Write, 0);

        // contention from reset release: A,B,A,B...
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        ReqA = 1'b1; AddrA = 13'd10; DataA = 18'h00001;
        ReqB = 1'b1; AddrB = 13'd20; DataB = 18'h00002;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_write", Write, 1);
            check("rr_waddr", WAddr, (i % 2 == 0) ? 10 : 20);
            check("rr_acka", AckA, (i % 2 == 0) ? 1 : 0);
            check("rr_ackb", AckB, (i % 2 == 0) ? 0 : 1);
        end

        // lone continuous A: every other cycle
        ReqB = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lone_write", Write, (i % 2 == 0) ? 1 : 0);
            check("lone_acka", AckA, (i % 2 == 0) ? 1 : 0);
        end
        ReqA = 1'b0;
        step();
        check("lone_end_write", Write, 0);

        // out-of-range A: ack without write, pointer still moves to A
        ReqA = 1'b1; AddrA = 13'd1920; DataA = 18'h3FFFF;
        step();
        check("oor_acka", AckA, 1);
        check("oor_write", Write, 0);
        ReqA = 1'b0;
        step();
        check("oor_gap_write", Write, 0);
        ReqA = 1'b1; AddrA = 13'd30; DataA = 18'h00030;
        ReqB = 1'b1; AddrB = 13'd1919; DataB = 18'h2ABCD;
        step();
        check("oor_tie_ackb", AckB, 1);
        check("oor_tie_acka", AckA, 0);
        check("oor_b_write", Write, 1);
        check("oor_b_waddr", WAddr, 1919);
        check("oor_b_wdata", WData, 18'h2ABCD);
        ReqB = 1'b0;
        step();
        check("oor_a_acka", AckA, 1);
        check("oor_a_waddr", WAddr, 30);
        ReqA = 1'b0;
        step();
        check("oor_end_write", Write, 0);

`ifdef TEXT_ARB_FILL_EN
        // full fill with ReqB held and a stray FillStart mid-fill
        FillStart = 1'b1; FillData = 18'h0F020;
        ReqB = 1'b1; AddrB = 13'd50; DataB = 18'h00007;
        step();
        FillStart = 1'b0; FillData = 18'h12345;
        busy_cnt = 0; seq_err = 0; exp_addr = '0;
        for (int i = 0; i < 2500 && FillBusy; i++) begin
            busy_cnt++;
            if (Write !== 1'b1 || WAddr !== exp_addr || WData !== 18'h0F020 || AckB !== 1'b0)
                seq_err++;
            exp_addr = exp_addr + 13'd1;
            FillStart = (i == 500);
            step();
        end
        FillStart = 1'b0;
        check("fill_busy_cycles", busy_cnt, 1920);
        check("fill_seq_errors", seq_err, 0);
        check("fill_end_write", Write, 0);
        check("fill_end_ackb", AckB, 0);
        step();
        check("fill_after_ackb", AckB, 1);
        check("fill_after_waddr", WAddr, 50);
        check("fill_after_write", Write, 1);
        ReqB = 1'b0;
        step();

        // reset mid-fill at address 100
        FillStart = 1'b1; FillData = 18'h0F020;
        step();
        FillStart = 1'b0;
        for (int i = 0; i < 200 && WAddr != 13'd100; i++) step();
        check("mid_waddr_100", WAddr, 100);
        Reset = 1'b1;
        step();
        check("mid_rst_write", Write, 0);
        check("mid_rst_busy", FillBusy, 0);
        check("mid_rst_waddr", WAddr, 0);
        Reset = 1'b0;
        step();
        check("mid_noresume_write", Write, 0);
        check("mid_noresume_busy", FillBusy, 0);
`else
        // fill engine absent: FillStart has no effect
        FillStart = 1'b1; FillData = 18'h0F020;
        step();
        FillStart = 1'b0;
        check("nofill_write", Write, 0);
        check("nofill_busy", FillBusy, 0);
        step();
        check("nofill_write2", Write, 0);
        check("nofill_busy2", FillBusy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
